// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder_if
// Description : Push port, UartTx handshake and status bundle for the feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tx_din;
    logic              tx_enable;
    logic              tx_ready;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              overflow;

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_din, tx_enable, count, busy, overflow
    );

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_din, tx_enable, count, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Byte FIFO plus issue FSM pulsing UartTx enable once per byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_X,
    uart_tx_feeder_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   C_FULL   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_1  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_1  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] wr_q,     wr_d;
    logic [ADDR_W-1:0] rd_q,     rd_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] tx_din_q, tx_din_d;
    logic              tx_en_q,  tx_en_d;
    logic              ovf_q,    ovf_d;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    always_comb begin
        w_full   = (count_q == C_FULL);
        w_push   = bus.in_valid && !w_full;
        w_pop    = (state_q == S_IDLE) && (count_q != '0) && bus.tx_ready;

        state_d  = state_q;
        tx_din_d = tx_din_q;
        tx_en_d  = 1'b0;
        wr_d     = w_push ? wr_q + C_PTR_1 : wr_q;
        rd_d     = w_pop  ? rd_q + C_PTR_1 : rd_q;
        ovf_d    = ovf_q | (bus.in_valid && w_full);

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_1;
            2'b01:   count_d = count_q - C_CNT_1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    tx_din_d = mem[rd_q];
                    tx_en_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_LO;
            S_WAIT_LO: if (!bus.tx_ready) state_d = S_WAIT_HI;
            S_WAIT_HI: if (bus.tx_ready)  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q  <= S_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            tx_din_q <= '0;
            tx_en_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            tx_din_q <= tx_din_d;
            tx_en_q  <= tx_en_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_push) mem[wr_q] <= bus.in_data;
    end

    assign bus.in_ready  = !w_full;
    assign bus.tx_din    = tx_din_q;
    assign bus.tx_enable = tx_en_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != S_IDLE) || (count_q != '0);
    assign bus.overflow  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Self-checking bench with a UartTx/receiver model and a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int BAUD  = 4;

    logic CLK = 1'b0;
    logic RST_X;
    logic hold;
    always #5 CLK = ~CLK;

    uart_tx_feeder_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(8)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: accepted bytes in order, issue count, sticky overflow.
    logic [7:0] exp_q [$];
    logic [7:0] iss_q [$];
    logic [7:0] rx_q  [$];
    int   n_acc = 0;
    int   n_iss = 0;
    int   long_pulse = 0;
    logic exp_ovf = 1'b0;
    logic prev_en = 1'b0;

    // UartTx model sharing the feeder reset.
    logic       u_ready, u_busy, txd;
    logic [9:0] u_sh;
    logic [3:0] u_bit;
    logic [7:0] u_cnt;
    logic [7:0] rx_b;

    assign bus.tx_ready = u_ready && !hold;

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            u_ready <= 1'b1; u_busy <= 1'b0; txd <= 1'b1;
            u_sh <= '0; u_bit <= '0; u_cnt <= '0;
        end else if (u_busy) begin
            if (u_cnt == 8'(BAUD - 1)) begin
                u_cnt <= '0;
                if (u_bit == 4'd9) begin
                    u_busy <= 1'b0; u_ready <= 1'b1; txd <= 1'b1;
                end else begin
                    u_bit <= u_bit + 4'd1;
                    txd   <= u_sh[u_bit + 4'd1];
                end
            end else begin
                u_cnt <= u_cnt + 8'd1;
            end
        end else if (u_ready && bus.tx_enable) begin
            u_sh <= {1'b1, bus.tx_din, 1'b0};
            txd <= 1'b0; u_busy <= 1'b1; u_ready <= 1'b0;
            u_bit <= '0; u_cnt <= '0;
        end
    end

    always begin
        @(negedge txd);
        repeat (BAUD / 2) @(posedge CLK);
        if (txd == 1'b0) begin
            for (int k = 0; k < 8; k++) begin
                repeat (BAUD) @(posedge CLK);
                rx_b[k] = txd;
            end
            rx_q.push_back(rx_b);
        end
    end

    always @(posedge CLK) begin
        #1;
        if (bus.tx_enable) begin
            iss_q.push_back(bus.tx_din);
            n_iss++;
            if (prev_en) long_pulse++;
        end
        prev_en = bus.tx_enable;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        if (n_acc - n_iss < DEPTH) begin
            exp_q.push_back(b);
            n_acc++;
        end else begin
            exp_ovf = 1'b1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (n_acc == n_iss && !bus.busy && u_ready && !hold) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic clear_model();
        exp_q.delete(); iss_q.delete(); rx_q.delete();
    endtask

    task automatic test_reset();
        RST_X = 1'b0; hold = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge CLK);
        tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests_run++; if (bus.tx_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_enable: got %b want 0", bus.tx_enable); end
        tests_run++; if (bus.tx_din !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_din: got %h want 00", bus.tx_din); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        RST_X = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_model();
        push(8'hA5);
        tests_run++; if (bus.tx_enable !== 1'b0) begin tests_failed++; $display("FAIL single_early_enable: got %b want 0", bus.tx_enable); end
        tests_run++; if (bus.count !== 5'd1) begin tests_failed++; $display("FAIL single_count1: got %0d want 1", bus.count); end
        @(negedge CLK);
        tests_run++; if (bus.tx_enable !== 1'b1) begin tests_failed++; $display("FAIL single_enable: got %b want 1", bus.tx_enable); end
        tests_run++; if (bus.tx_din !== 8'hA5) begin tests_failed++; $display("FAIL single_din: got %h want a5", bus.tx_din); end
        tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL single_count0: got %0d want 0", bus.count); end
        @(negedge CLK);
        tests_run++; if (bus.tx_enable !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width: got %b want 0", bus.tx_enable); end
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_drain: got timeout want idle"); end
        repeat (4 * BAUD) @(negedge CLK);
        tests_run++; if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL single_rx_count: got %0d want 1", rx_q.size()); end
        else begin
            tests_run++; if (rx_q[0] !== 8'hA5) begin tests_failed++; $display("FAIL single_rx_byte: got %h want a5", rx_q[0]); end
        end
    endtask

    task automatic test_burst_overflow();
        bit ok;
        clear_model();
        hold = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        tests_run++; if (bus.count !== 5'd16) begin tests_failed++; $display("FAIL burst_full_count: got %0d want 16", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL burst_in_ready: got %b want 0", bus.in_ready); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL burst_early_overflow: got %b want 0", bus.overflow); end
        push(8'hFF);
        tests_run++; if (bus.overflow !== exp_ovf) begin tests_failed++; $display("FAIL burst_overflow: got %b want %b", bus.overflow, exp_ovf); end
        tests_run++; if (bus.count !== 5'd16) begin tests_failed++; $display("FAIL burst_count_after_drop: got %0d want 16", bus.count); end
        hold = 1'b0;
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL burst_drain: got timeout want idle"); end
        tests_run++; if (iss_q.size() !== 16) begin tests_failed++; $display("FAIL burst_pulses: got %0d want 16", iss_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            tests_run++; if (iss_q[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL burst_order[%0d]: got %h want %h", i, iss_q[i], 8'(i + 1)); end
        end
        tests_run++; if (long_pulse !== 0) begin tests_failed++; $display("FAIL burst_pulse_width: got %0d long pulses want 0", long_pulse); end
        tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL burst_end_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL burst_end_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [7:0] a, b;
        clear_model();
        a = 8'($urandom); b = 8'($urandom);
        hold = 1'b1;
        push(a);
        tests_run++; if (bus.count !== 5'd1) begin tests_failed++; $display("FAIL simul_pre_count: got %0d want 1", bus.count); end
        exp_q.push_back(b); n_acc++;
        bus.in_data = b; bus.in_valid = 1'b1; hold = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        tests_run++; if (bus.count !== 5'd1) begin tests_failed++; $display("FAIL simul_count: got %0d want 1", bus.count); end
        tests_run++; if (bus.tx_din !== a) begin tests_failed++; $display("FAIL simul_head: got %h want %h", bus.tx_din, a); end
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL simul_drain: got timeout want idle"); end
        tests_run++; if (iss_q.size() !== 2) begin tests_failed++; $display("FAIL simul_pulses: got %0d want 2", iss_q.size()); end
        else begin
            tests_run++; if (iss_q[1] !== b) begin tests_failed++; $display("FAIL simul_second: got %h want %h", iss_q[1], b); end
        end
    endtask

    task automatic test_hold();
        bit ok;
        clear_model();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (20) @(negedge CLK);
        tests_run++; if (iss_q.size() !== 0) begin tests_failed++; $display("FAIL hold_no_pulse: got %0d pulses want 0", iss_q.size()); end
        tests_run++; if (bus.count !== 5'd3) begin tests_failed++; $display("FAIL hold_count: got %0d want 3", bus.count); end
        hold = 1'b0;
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL hold_drain: got timeout want idle"); end
        tests_run++; if (iss_q.size() !== 3) begin tests_failed++; $display("FAIL hold_pulses: got %0d want 3", iss_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests_run++; if (iss_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL hold_order[%0d]: got %h want %h", i, iss_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        for (int i = 0; i < 6; i++) push(8'($urandom));
        tests_run++; if (bus.count !== 5'd5) begin tests_failed++; $display("FAIL rmid_queued: got %0d want 5", bus.count); end
        RST_X = 1'b0;
        #1;
        tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL rmid_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.tx_enable !== 1'b0) begin tests_failed++; $display("FAIL rmid_enable: got %b want 0", bus.tx_enable); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL rmid_overflow: got %b want 0", bus.overflow); end
        n_acc = 0; n_iss = 0; exp_ovf = 1'b0;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        repeat (12 * BAUD) @(negedge CLK);
        clear_model();
        push(8'h3C);
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rmid_drain: got timeout want idle"); end
        repeat (4 * BAUD) @(negedge CLK);
        tests_run++; if (iss_q.size() !== 1 || rx_q.size() !== 1) begin tests_failed++; $display("FAIL rmid_sizes: got %0d/%0d want 1/1", iss_q.size(), rx_q.size()); end
        else begin
            tests_run++; if (iss_q[0] !== 8'h3C) begin tests_failed++; $display("FAIL rmid_din: got %h want 3c", iss_q[0]); end
            tests_run++; if (rx_q[0] !== 8'h3C) begin tests_failed++; $display("FAIL rmid_rx: got %h want 3c", rx_q[0]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int occ;
        clear_model();
        for (int i = 0; i < 600; i++) begin
            occ = n_acc - n_iss;
            tests_run++; if (bus.count !== 5'(occ)) begin tests_failed++; $display("FAIL rand_count@%0d: got %0d want %0d", i, bus.count, occ); end
            tests_run++; if (bus.in_ready !== (occ != DEPTH)) begin tests_failed++; $display("FAIL rand_in_ready@%0d: got %b want %b", i, bus.in_ready, occ != DEPTH); end
            tests_run++; if (bus.overflow !== exp_ovf) begin tests_failed++; $display("FAIL rand_overflow@%0d: got %b want %b", i, bus.overflow, exp_ovf); end
            hold = ((i % 200) < 80) || ($urandom_range(0, 7) == 0);
            bus.in_data  = 8'($urandom);
            bus.in_valid = $urandom_range(0, 1) == 1;
            if (bus.in_valid) begin
                if (occ < DEPTH) begin exp_q.push_back(bus.in_data); n_acc++; end
                else exp_ovf = 1'b1;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        bus.in_valid = 1'b0;
        hold = 1'b0;
        drain(ok);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL rand_drain: got timeout want idle"); end
        tests_run++; if (iss_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand_pulses: got %0d want %0d", iss_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++; if (iss_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand_order[%0d]: got %h want %h", i, iss_q[i], exp_q[i]); end
        end
        tests_run++; if (long_pulse !== 0) begin tests_failed++; $display("FAIL rand_pulse_width: got %0d long pulses want 0", long_pulse); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
